vga_scanout: RTL and testbench
==============================

Name: vga_scanout

Overview:
- Reader side of the frame-buffer interface. The drawing engine writes 3-bit mega-pixels at 160x120 into the buffer; this block reads them back and produces 640x480@60 Hz VGA timing.
- Each mega-pixel is replicated 4x4 on screen.
- Generates the buffer read address, expands the 3-bit colour to 24-bit RGB, and emits sync and blank signals.
- Also emits a once-per-frame tick, usable as the draw engine's frame-start strobe.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- MEGA_W, 160, buffer width in mega-pixels (scale factor 4 is fixed)

Ports:
- clock50Mhz  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous active-low reset
- rd_addr  out  15  frame-buffer read address, y_mega*160 + x_mega
- rd_data  in  3  buffer read data, valid exactly one clock after rd_addr; bit2=R, bit1=G, bit0=B
- VGA_R  out  8  red
- VGA_G  out  8  green
- VGA_B  out  8  blue
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  high only during visible pixels
- VGA_SYNC_N  out  1  tied 0
- pix_en  out  1  25 MHz pixel strobe (VGA_CLK source), high every second clock
- frame_tick  out  1  one-clock pulse at start of vertical blanking

Behaviour:
- Reset: one clock, asynchronous, active-low.
  - Reset values: pix_en=0, h_cnt=0, v_cnt=0, rd_addr=0, VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, frame_tick=0.
  - Reset asserted mid-line or mid-frame forces these values immediately. After release, scan restarts at (0,0).
- Pixel strobe: pix_en toggles every clock. The first clock after reset release sets it to 1.
- Counters: advance only on clocks where pix_en=1.
  - h_cnt: 0..799 (total = sum of H parameters); wraps to 0 after 799.
  - v_cnt: 0..524; increments when h_cnt wraps, and wraps to 0 after 524.
- Address: rd_addr is registered and updated on the same edge as the counters, from the new values.
  - x_mega = h_cnt>>2, y_mega = v_cnt>>2.
  - rd_addr = y_mega*160 + x_mega, computed with shift-add: (y<<7)+(y<<5)+x.
  - Outside the visible region rd_addr holds 0.
  - Range 0..19199; never exceeds 19199.
- Output pipeline: all VGA outputs are registered and updated only on pix_en=1 edges.
  - Each output reflects the counter value of the previous pixel (1 pixel = 2 clocks of latency).
  - rd_data is sampled one clock after the address is issued, within the pixel period.
- Derived signals for a counter value (h,v):
  - visible = h<640 && v<480.
  - HS low for 656<=h<752.
  - VS low for 490<=v<492.
  - BLANK_N = visible.
  - Colour channel = 8'hFF if its bit is set and visible, else 8'h00. Blanked pixels always output 0 regardless of rd_data.
- frame_tick:
  - Asserted for one clock: the clock on which (h_cnt,v_cnt) becomes (0,480).
  - Exactly one pulse per 840000 clocks.
  - Not asserted in the first frame until v_cnt reaches 480.
- Frame-buffer contention: none from this block. The block is read-only; write-port contention is resolved by the dual-port buffer.
- Boundary at line end: h wrap and v increment occur on the same edge.
  - At (799,524) both wrap to (0,0).
  - rd_addr returns to 0 on that edge.

Test Plan:
- Reset: hold resetn=0 for 5 clocks with random rd_data -> VGA_HS=1, VGA_VS=1, BLANK_N=0, RGB=0, rd_addr=0, frame_tick=0. Assert resetn=0 mid-line at h=300 -> outputs return to reset values without waiting for a clock edge.
- Horizontal timing: run 3 lines -> HS period 1600 clocks, low for 192 clocks, falling edge 1312 clocks (656 pixels) after BLANK_N rises; BLANK_N high 1280 clocks per line.
- Vertical timing and frame tick: run 2 frames -> VS period 840000 clocks, low for 3200 clocks; frame_tick exactly once per 840000 clocks, coincident with first line after v=479.
- Addressing: model memory as addr[2:0] -> rd_addr = 0 for h=0..3,v=0; 1 at h=4; 159 at h=636; 160 at h=0,v=4; 19199 at h=636..639,v=476..479; 0 during blanking.
- Colour expansion: memory returns 3'b101 everywhere -> visible pixels RGB=(FF,00,FF), blanking pixels (0,0,0). Memory returns 3'b010 -> (00,FF,00).
- Latency: a distinct value at address 1 only -> RGB changes exactly 2 clocks after the counter reaches h=4,v=0, and is held for 4 pixels.

Source files
------------

// File: rtl/vga_scanout.sv
// Frame-buffer reader: scans 640x480@60 from a 160x120 3-bit buffer, each mega-pixel shown 4x4.
// Latency: outputs lag the counters by one pixel (2 clocks); free-running, no backpressure.
module vga_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int MEGA_W    = 160
) (
    input  logic        clock50Mhz,
    input  logic        resetn,
    output logic [14:0] rd_addr,
    input  logic [2:0]  rd_data,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        pix_en,
    output logic        frame_tick
);
    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic        r_pix_en;
    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic [14:0] r_rd_addr;
    logic [2:0]  r_rd_data;
    logic [7:0]  r_red;
    logic [7:0]  r_grn;
    logic [7:0]  r_blu;
    logic        r_hs;
    logic        r_vs;
    logic        r_blank_n;
    logic        r_frame_tick;

    logic        w_h_wrap;
    logic [9:0]  w_h_next;
    logic [9:0]  w_v_next;
    logic        w_vis_next;
    logic        w_vis;
    logic        w_tick_next;
    logic [14:0] w_x_mega;
    logic [14:0] w_y_mega;
    logic [14:0] w_row_base;
    logic [14:0] w_addr_next;

    assign w_h_wrap    = (r_h_cnt == H_LAST);
    assign w_h_next    = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
    assign w_v_next    = !w_h_wrap ? r_v_cnt : ((r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1);
    assign w_vis_next  = (w_h_next < H_VIS) && (w_v_next < V_VIS);
    assign w_vis       = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    assign w_tick_next = (w_h_next == 10'd0) && (w_v_next == V_VIS);

    assign w_x_mega = {7'd0, w_h_next[9:2]};
    assign w_y_mega = {7'd0, w_v_next[9:2]};

    generate
        if (MEGA_W == 160) begin : g_shift_add
            assign w_row_base = (w_y_mega << 7) + (w_y_mega << 5);
        end else begin : g_mul
            assign w_row_base = 15'(w_y_mega * MEGA_W);
        end
    endgenerate

    assign w_addr_next = w_row_base + w_x_mega;

    // Address is issued on a pix_en edge; the data is captured on the following
    // (non-pixel) edge and turned into colour on the next pixel edge.
    always_ff @(posedge clock50Mhz or negedge resetn) begin
        if (!resetn) begin
            r_pix_en     <= 1'b0;
            r_h_cnt      <= 10'd0;
            r_v_cnt      <= 10'd0;
            r_rd_addr    <= 15'd0;
            r_rd_data    <= 3'd0;
            r_red        <= 8'h00;
            r_grn        <= 8'h00;
            r_blu        <= 8'h00;
            r_hs         <= 1'b1;
            r_vs         <= 1'b1;
            r_blank_n    <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_pix_en     <= ~r_pix_en;
            r_frame_tick <= 1'b0;
            if (!r_pix_en) begin
                r_rd_data <= rd_data;
            end else begin
                r_h_cnt      <= w_h_next;
                r_v_cnt      <= w_v_next;
                r_rd_addr    <= w_vis_next ? w_addr_next : 15'd0;
                r_frame_tick <= w_tick_next;
                r_red        <= {8{w_vis & r_rd_data[2]}};
                r_grn        <= {8{w_vis & r_rd_data[1]}};
                r_blu        <= {8{w_vis & r_rd_data[0]}};
                r_hs         <= ~((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
                r_vs         <= ~((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));
                r_blank_n    <= w_vis;
            end
        end
    end

    assign pix_en      = r_pix_en;
    assign rd_addr     = r_rd_addr;
    assign VGA_R       = r_red;
    assign VGA_G       = r_grn;
    assign VGA_B       = r_blu;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_SYNC_N  = 1'b0;
    assign frame_tick  = r_frame_tick;
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout with a shortened vertical frame (16 lines) so two whole frames fit the run.
// Expected outputs come from a linear pixel-index model; monitor pops and compares every clock.
module tb_vga_scanout;
    localparam int HT = 800;
    localparam int VV = 12;
    localparam int VT = 16;
    localparam int VS0 = 13;
    localparam int VS1 = 15;

    typedef struct packed {
        logic        pe;
        logic [14:0] addr;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        hs;
        logic        vs;
        logic        bn;
        logic        sn;
        logic        tick;
    } exp_t;

    typedef struct packed {
        exp_t        e;
        logic [31:0] n;
        logic [7:0]  ph;
    } item_t;

    typedef struct packed {
        logic [7:0]  ph;
        logic [31:0] n;
        logic [14:0] addr;
        logic        tick;
        logic        hs;
        logic        vs;
        logic        bn;
        logic [7:0]  r;
    } spot_t;

    logic        clk;
    logic        resetn;
    logic [14:0] rd_addr;
    logic [2:0]  rd_data;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic        vga_sync_n;
    logic        pix_en;
    logic        frame_tick;

    int     mode;
    int     n;
    int     checks;
    int     errors;
    item_t  sb_q[$];
    spot_t  spots[$];

    vga_scanout #(
        .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_VISIBLE(VV), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .MEGA_W(160)
    ) dut (
        .clock50Mhz (clk),
        .resetn     (resetn),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .VGA_R      (vga_r),
        .VGA_G      (vga_g),
        .VGA_B      (vga_b),
        .VGA_HS     (vga_hs),
        .VGA_VS     (vga_vs),
        .VGA_BLANK_N(vga_blank_n),
        .VGA_SYNC_N (vga_sync_n),
        .pix_en     (pix_en),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [14:0] addr_of(int h, int v);
        if (h < 640 && v < VV) return 15'((v / 4) * 160 + h / 4);
        return 15'd0;
    endfunction

    function automatic logic [2:0] mem(int m, logic [14:0] a);
        case (m)
            0:       return a[2:0];
            1:       return 3'b101;
            2:       return 3'b010;
            default: return (a == 15'd1) ? 3'b111 : 3'b000;
        endcase
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        return e;
    endfunction

    // n = clock edges since reset release; counter index after edge n is n/2,
    // and the outputs after edge n describe pixel n/2-1.
    function automatic exp_t exp_at(int k, int m);
        exp_t e;
        int c, h, v, p, ph, pv;
        logic [2:0] d;
        logic vis;
        e = reset_exp();
        c = k / 2;
        h = c % HT;
        v = (c / HT) % VT;
        e.pe   = (k % 2 == 1);
        e.addr = addr_of(h, v);
        e.tick = (k % 2 == 0) && (c % (HT * VT) == VV * HT);
        if (k >= 2) begin
            p    = c - 1;
            ph   = p % HT;
            pv   = (p / HT) % VT;
            vis  = (ph < 640) && (pv < VV);
            d    = mem(m, addr_of(ph, pv));
            e.hs = !(ph >= 656 && ph < 752);
            e.vs = !(pv >= VS0 && pv < VS1);
            e.bn = vis;
            e.r  = (vis && d[2]) ? 8'hFF : 8'h00;
            e.g  = (vis && d[1]) ? 8'hFF : 8'h00;
            e.b  = (vis && d[0]) ? 8'hFF : 8'h00;
        end
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t s;
        s.pe = pix_en; s.addr = rd_addr;
        s.r = vga_r; s.g = vga_g; s.b = vga_b;
        s.hs = vga_hs; s.vs = vga_vs; s.bn = vga_blank_n;
        s.sn = vga_sync_n; s.tick = frame_tick;
        return s;
    endfunction

    function automatic string fmt(exp_t e);
        return $sformatf("pe=%b addr=%0d rgb=%h/%h/%h hs=%b vs=%b bn=%b sn=%b tick=%b",
                         e.pe, e.addr, e.r, e.g, e.b, e.hs, e.vs, e.bn, e.sn, e.tick);
    endfunction

    // Frame-buffer model: data valid one clock after the address; random while in reset.
    initial begin
        rd_data = 3'd0;
        forever begin
            @(clk);
            #1;
            if (!resetn) rd_data = 3'($urandom_range(0, 7));
            else         rd_data = mem(mode, rd_addr);
        end
    end

    // Monitor: one expected entry per clock edge.
    initial begin
        item_t it;
        exp_t  act;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                it  = sb_q.pop_front();
                act = sample();
                checks++;
                if (act !== it.e) begin
                    errors++;
                    $display("FAIL scoreboard ph=%0d n=%0d got {%s} expected {%s}",
                             it.ph, it.n, fmt(act), fmt(it.e));
                end
            end
        end
    end

    task automatic hold_reset(int k, int ph);
        repeat (k) begin
            sb_q.push_back('{e: reset_exp(), n: 32'd0, ph: 8'(ph)});
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset(int k, int ph);
        @(negedge clk);
        resetn = 1'b0;
        hold_reset(k, ph);
        resetn = 1'b1;
        n = 0;
    endtask

    task automatic spot_check(int ph);
        foreach (spots[i]) begin
            if (spots[i].ph == 8'(ph) && spots[i].n == 32'(n)) begin
                checks++;
                if ({rd_addr, frame_tick, vga_hs, vga_vs, vga_blank_n, vga_r} !==
                    {spots[i].addr, spots[i].tick, spots[i].hs, spots[i].vs, spots[i].bn, spots[i].r}) begin
                    errors++;
                    $display("FAIL spot ph=%0d n=%0d got addr=%0d tick=%b hs=%b vs=%b bn=%b r=%h expected addr=%0d tick=%b hs=%b vs=%b bn=%b r=%h",
                             ph, n, rd_addr, frame_tick, vga_hs, vga_vs, vga_blank_n, vga_r,
                             spots[i].addr, spots[i].tick, spots[i].hs, spots[i].vs, spots[i].bn, spots[i].r);
                end
            end
        end
    endtask

    task automatic run(int ph, int cnt);
        repeat (cnt) begin
            n++;
            sb_q.push_back('{e: exp_at(n, mode), n: 32'(n), ph: 8'(ph)});
            @(posedge clk);
            #2;
            spot_check(ph);
            @(negedge clk);
        end
    endtask

    task automatic add_spot(int ph, int k, int a, bit t, bit h, bit v, bit b, logic [7:0] r);
        spots.push_back('{ph: 8'(ph), n: 32'(k), addr: 15'(a), tick: t, hs: h, vs: v, bn: b, r: r});
    endtask

    initial begin
        exp_t act;
        resetn = 1'b0;
        mode   = 0;
        n      = 0;
        checks = 0;
        errors = 0;

        //       ph  n      addr tick hs vs bn  r
        add_spot(1,  1,     0,   0,   1, 1, 0, 8'h00);
        add_spot(1,  2,     0,   0,   1, 1, 1, 8'h00);
        add_spot(1,  8,     1,   0,   1, 1, 1, 8'h00);
        add_spot(1,  1272,  159, 0,   1, 1, 1, 8'hFF);
        add_spot(1,  1280,  0,   0,   1, 1, 1, 8'hFF);
        add_spot(1,  1282,  0,   0,   1, 1, 0, 8'h00);
        add_spot(1,  1312,  0,   0,   1, 1, 0, 8'h00);
        add_spot(1,  1314,  0,   0,   0, 1, 0, 8'h00);
        add_spot(1,  1504,  0,   0,   0, 1, 0, 8'h00);
        add_spot(1,  1506,  0,   0,   1, 1, 0, 8'h00);
        add_spot(1,  6400,  160, 0,   1, 1, 0, 8'h00);
        add_spot(1,  18872, 479, 0,   1, 1, 1, 8'hFF);
        add_spot(1,  19200, 0,   1,   1, 1, 0, 8'h00);
        add_spot(1,  19201, 0,   0,   1, 1, 0, 8'h00);
        add_spot(1,  20802, 0,   0,   1, 0, 0, 8'h00);
        add_spot(1,  24002, 0,   0,   1, 1, 0, 8'h00);
        add_spot(1,  25600, 0,   0,   1, 1, 0, 8'h00);
        add_spot(1,  25608, 1,   0,   1, 1, 1, 8'h00);
        add_spot(1,  44800, 0,   1,   1, 1, 0, 8'h00);
        add_spot(2,  2,     0,   0,   1, 1, 1, 8'hFF);
        add_spot(5,  8,     1,   0,   1, 1, 1, 8'h00);
        add_spot(5,  9,     1,   0,   1, 1, 1, 8'h00);
        add_spot(5,  10,    1,   0,   1, 1, 1, 8'hFF);
        add_spot(5,  16,    2,   0,   1, 1, 1, 8'hFF);
        add_spot(5,  17,    2,   0,   1, 1, 1, 8'hFF);
        add_spot(5,  18,    2,   0,   1, 1, 1, 8'h00);

        // Addressing, timing and two full frames.
        do_reset(5, 0);
        run(1, 51300);

        mode = 1;
        do_reset(3, 0);
        run(2, 2000);

        // Reset asserted mid-line at h=300 must take effect without a clock edge.
        mode = 2;
        do_reset(3, 0);
        run(3, 600);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        act = sample();
        checks++;
        if (act !== reset_exp()) begin
            errors++;
            $display("FAIL midline_reset got {%s} expected {%s}", fmt(act), fmt(reset_exp()));
        end
        @(negedge clk);
        hold_reset(2, 0);
        resetn = 1'b1;
        n = 0;
        run(4, 3300);

        mode = 3;
        do_reset(3, 0);
        run(5, 1700);

        @(posedge clk);
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
